edge_detector_mc: RTL and testbench

EDGE_DETECTOR_MC -- requirements
Module: edge_detector_mc

---
 rtl/edge_detector_pkg.sv | 17 +
 rtl/edge_detector_mc_chan.sv | 87 ++++++++
 rtl/edge_detector_mc.sv | 65 ++++++
 tb/tb_edge_detector_mc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg: shared types and parameter limits for edge_detector_mc.
//   edge_mode_t      - per-channel edge selection encoding (2 bits)
//   MIN_SYNC_STAGES  - smallest legal synchroniser depth
//   MIN_FILTER_LEN   - smallest legal filter length (1 = no filtering)
package edge_detector_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_FILTER_LEN  = 1;

endpackage

// File: rtl/edge_detector_mc_chan.sv
// edge_chan: one channel of the edge detector.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   async_i           - asynchronous input bit
//   en_rise_i/en_fall_i - decoded mode: which edges drive strobe_o
//   clr_i             - pending clear pulse
//   level_o           - filtered, synchronised level
//   rise_o/fall_o     - registered one-cycle edge pulses
//   strobe_o          - mode-selected edge pulse (combinational)
//   pending_o         - sticky flag set by strobe_o
module edge_chan
    import edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    input  logic en_rise_i,
    input  logic en_fall_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic strobe_o,
    output logic pending_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   pending_q, pending_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Filter: count consecutive cycles where the synchronised input disagrees
    // with the accepted level; any agreement restarts the count from zero.
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != lvl_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                lvl_d  = ~lvl_q;
                rise_d = ~lvl_q;
                fall_d = lvl_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign strobe_o = (rise_q & en_rise_i) | (fall_q & en_fall_i);

    // Set has priority over clear so a coincident strobe is never lost.
    assign pending_d = strobe_o | (pending_q & ~clr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_i};
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    assign level_o   = lvl_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/edge_detector_mc.sv
// edge_detector_mc: N_CH independent synchronised, glitch-filtered edge
// detectors with per-channel mode select and sticky pending flags.
//   clk_i, rst_i - clock, synchronous active-high reset
//   async_i      - asynchronous channel inputs [N_CH]
//   mode_i       - per-channel edge mode, channel c at [2c+1:2c]
//   clr_i        - per-channel pending clear [N_CH]
//   level_o      - filtered levels; rise_o/fall_o - edge pulses
//   strobe_o     - mode-selected pulses; pending_o - sticky flags
module edge_detector_mc
    import edge_detector_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH-1:0]   async_i,
    input  logic [2*N_CH-1:0] mode_i,
    input  logic [N_CH-1:0]   clr_i,
    output logic [N_CH-1:0]   level_o,
    output logic [N_CH-1:0]   rise_o,
    output logic [N_CH-1:0]   fall_o,
    output logic [N_CH-1:0]   strobe_o,
    output logic [N_CH-1:0]   pending_o
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("edge_detector_mc: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < MIN_FILTER_LEN) begin : g_bad_filt
        $error("edge_detector_mc: FILTER_LEN must be >= 1");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("edge_detector_mc: N_CH must be >= 1");
    end

    logic [N_CH-1:0] en_rise;
    logic [N_CH-1:0] en_fall;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        edge_mode_t mode_c;
        assign mode_c     = edge_mode_t'(mode_i[2*c +: 2]);
        assign en_rise[c] = (mode_c == EDGE_RISE) || (mode_c == EDGE_BOTH);
        assign en_fall[c] = (mode_c == EDGE_FALL) || (mode_c == EDGE_BOTH);

        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .async_i   (async_i[c]),
            .en_rise_i (en_rise[c]),
            .en_fall_i (en_fall[c]),
            .clr_i     (clr_i[c]),
            .level_o   (level_o[c]),
            .rise_o    (rise_o[c]),
            .fall_o    (fall_o[c]),
            .strobe_o  (strobe_o[c]),
            .pending_o (pending_o[c])
        );
    end

endmodule

// File: tb/tb_edge_detector_mc.sv
module tb_edge_detector_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: defaults
    logic       rst;
    logic [3:0] async_v, clr, lvl, rise, fall, stb, pnd;
    logic [7:0] mode;

    edge_detector_mc u_a (
        .clk_i(clk), .rst_i(rst), .async_i(async_v), .mode_i(mode), .clr_i(clr),
        .level_o(lvl), .rise_o(rise), .fall_o(fall), .strobe_o(stb), .pending_o(pnd)
    );

    // DUT B: FILTER_LEN=1, SYNC_STAGES=3, single channel
    logic       rst2, async2, clr2, lvl2, rise2, fall2, stb2, pnd2;
    logic [1:0] mode2;

    edge_detector_mc #(.N_CH(1), .SYNC_STAGES(3), .FILTER_LEN(1)) u_b (
        .clk_i(clk), .rst_i(rst2), .async_i(async2), .mode_i(mode2), .clr_i(clr2),
        .level_o(lvl2), .rise_o(rise2), .fall_o(fall2), .strobe_o(stb2), .pending_o(pnd2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] clr;
        logic [3:0] e_lvl, e_rise, e_fall, e_stb, e_pnd;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int rc, fc, sc, rpos, fpos;

        // ch0 rise detect, pending set/clear, then a 3-cycle glitch on ch1
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 2; i <= 6; i++)
            tbl[i] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
        tbl[8]  = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
        tbl[9]  = '{1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 10; i <= 12; i++)
            tbl[i] = '{1'b0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 13; i <= 17; i++)
            tbl[i] = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};

        rst = 1'b1; async_v = '0; clr = '0; mode = 8'h20;  // ch2 both, others rise
        rst2 = 1'b1; async2 = 1'b0; clr2 = 1'b0; mode2 = 2'b11;

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; async_v = tbl[i].a; clr = tbl[i].clr;
            step();
            chk($sformatf("row%0d level", i), {28'd0, lvl},  {28'd0, tbl[i].e_lvl});
            chk($sformatf("row%0d rise", i),  {28'd0, rise}, {28'd0, tbl[i].e_rise});
            chk($sformatf("row%0d fall", i),  {28'd0, fall}, {28'd0, tbl[i].e_fall});
            chk($sformatf("row%0d strobe", i),{28'd0, stb},  {28'd0, tbl[i].e_stb});
            chk($sformatf("row%0d pending", i),{28'd0, pnd}, {28'd0, tbl[i].e_pnd});
        end
        clr = '0;

        // ch2 in both-edge mode: high 10 cycles then low 10 cycles
        rc = 0; fc = 0; sc = 0; rpos = 0; fpos = 0;
        async_v = 4'b0101;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (rise[2]) begin rc++; rpos = i; end
            if (fall[2]) fc++;
            if (stb[2]) sc++;
        end
        async_v = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (rise[2]) rc++;
            if (fall[2]) begin fc++; fpos = i; end
            if (stb[2]) sc++;
        end
        chk("ch2 rise count", rc, 1);
        chk("ch2 fall count", fc, 1);
        chk("ch2 strobe count", sc, 2);
        chk("ch2 rise latency", rpos, 6);
        chk("ch2 fall latency", fpos, 6);
        chk("ch2 pending", {31'd0, pnd[2]}, 1);
        chk("ch2 level low", {31'd0, lvl[2]}, 0);
        chk("ch0 level kept", {31'd0, lvl[0]}, 1);

        // ch3: strobe coincident with clear, mode change is combinational
        async_v = 4'b1001;
        for (int i = 1; i <= 6; i++) step();
        chk("ch3 rise", {28'd0, rise}, 32'h8);
        chk("ch3 strobe", {31'd0, stb[3]}, 1);
        chk("ch3 pending before", {31'd0, pnd[3]}, 0);
        mode[7:6] = 2'b11;
        #1;
        chk("ch3 strobe off mode", {31'd0, stb[3]}, 0);
        mode[7:6] = 2'b00;
        #1;
        chk("ch3 strobe restored", {31'd0, stb[3]}, 1);
        clr = 4'b1000;
        step();
        chk("ch3 set beats clr", {31'd0, pnd[3]}, 1);
        step();
        chk("ch3 clr alone", {31'd0, pnd[3]}, 0);
        clr = '0;

        // reset two cycles into a filter count on ch1
        async_v = 4'b0010;
        for (int i = 1; i <= 4; i++) step();
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            chk($sformatf("rst%0d pulses", i), {28'd0, rise | fall | stb}, 0);
            chk($sformatf("rst%0d level", i), {28'd0, lvl}, 0);
            chk($sformatf("rst%0d pending", i), {28'd0, pnd}, 0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("post-rst%0d rise", i), {28'd0, rise}, (i == 6) ? 32'h2 : 32'h0);
        end
        chk("post-rst level", {28'd0, lvl}, 32'h2);

        // DUT B: short filter, deeper synchroniser, edges disabled in mode
        step(); step();
        rst2 = 1'b0;
        async2 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("b rise%0d", i), {31'd0, rise2}, (i == 4) ? 1 : 0);
            chk($sformatf("b strobe%0d", i), {31'd0, stb2}, 0);
        end
        chk("b level high", {31'd0, lvl2}, 1);
        async2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("b fall%0d", i), {31'd0, fall2}, (i == 4) ? 1 : 0);
            chk($sformatf("b fstrobe%0d", i), {31'd0, stb2}, 0);
        end
        chk("b level low", {31'd0, lvl2}, 0);
        chk("b pending", {31'd0, pnd2}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
